// File: rtl/aes_job_sequencer.sv
// Runs one complete AES job on the memory-mapped aes wrapper for each accepted request:
// config, optional key load/init, block load/next, status polling and result readback.
module aes_job_sequencer #(
  parameter int POLL_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_key,
  input  logic [127:0] job_block,
  input  logic         job_encdec,
  input  logic         job_keylen,
  input  logic         job_key_reuse,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_err,
  output logic         busy,
  output logic         aes_cs,
  output logic         aes_we,
  output logic [7:0]   aes_address,
  output logic [31:0]  aes_write_data,
  input  logic [31:0]  aes_read_data
);
  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0a;

  typedef enum logic [3:0] {
    IDLE, WR_CFG, WR_KEY, WR_INIT, SETTLE, POLL_RDY,
    WR_BLK, WR_NEXT, POLL_VLD, RD_RES, RESP
  } state_t;

  state_t         state;
  logic [255:0]   key_q, loaded_key;
  logic [127:0]   block_q;
  logic           encdec_q, keylen_q, reuse_q;
  logic           key_loaded, loaded_keylen;
  logic [3:0]     idx;
  logic [3:0]     idx_m1;
  logic [SW-1:0]  settle_cnt;
  logic           settle_vld;
  logic [PW-1:0]  poll_cnt;
  logic           poll_chk;
  logic           key_hit;
  logic           poll_bit;

  assign idx_m1   = idx - 4'd1;
  assign key_hit  = reuse_q & key_loaded & (keylen_q == loaded_keylen) & (key_q == loaded_key);
  assign poll_bit = (state == POLL_RDY) ? aes_read_data[0] : aes_read_data[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      job_ready      <= 1'b1;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_err        <= 1'b0;
      busy           <= 1'b0;
      aes_cs         <= 1'b0;
      aes_we         <= 1'b0;
      aes_address    <= '0;
      aes_write_data <= '0;
      key_q          <= '0;
      block_q        <= '0;
      encdec_q       <= 1'b0;
      keylen_q       <= 1'b0;
      reuse_q        <= 1'b0;
      key_loaded     <= 1'b0;
      loaded_key     <= '0;
      loaded_keylen  <= 1'b0;
      idx            <= '0;
      settle_cnt     <= '0;
      settle_vld     <= 1'b0;
      poll_cnt       <= '0;
      poll_chk       <= 1'b0;
    end else begin
      // bus is idle unless a state below issues an access for the next cycle
      aes_cs         <= 1'b0;
      aes_we         <= 1'b0;
      aes_address    <= '0;
      aes_write_data <= '0;
      case (state)
        IDLE: begin
          if (job_valid) begin
            key_q          <= job_key;
            block_q        <= job_block;
            encdec_q       <= job_encdec;
            keylen_q       <= job_keylen;
            reuse_q        <= job_key_reuse;
            res_data       <= '0;
            job_ready      <= 1'b0;
            busy           <= 1'b1;
            state          <= WR_CFG;
            aes_cs         <= 1'b1;
            aes_we         <= 1'b1;
            aes_address    <= ADDR_CONFIG;
            aes_write_data <= {30'b0, job_keylen, job_encdec};
          end
        end
        WR_CFG: begin
          idx    <= 4'd1;
          aes_cs <= 1'b1;
          aes_we <= 1'b1;
          if (key_hit) begin
            state          <= WR_BLK;
            aes_address    <= 8'h20;
            aes_write_data <= block_q[31:0];
          end else begin
            state          <= WR_KEY;
            aes_address    <= 8'h10;
            aes_write_data <= key_q[31:0];
          end
        end
        WR_KEY: begin
          aes_cs <= 1'b1;
          aes_we <= 1'b1;
          if (idx == 4'd8) begin
            state          <= WR_INIT;
            aes_address    <= ADDR_CTRL;
            aes_write_data <= 32'h1;
          end else begin
            aes_address    <= {4'h1, idx};
            aes_write_data <= key_q[{idx[2:0], 5'b0} +: 32];
            idx            <= idx + 4'd1;
          end
        end
        WR_INIT: begin
          state      <= SETTLE;
          settle_vld <= 1'b0;
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state       <= settle_vld ? POLL_VLD : POLL_RDY;
            poll_cnt    <= '0;
            poll_chk    <= 1'b0;
            aes_cs      <= 1'b1;
            aes_address <= ADDR_STATUS;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        POLL_RDY, POLL_VLD: begin
          if (poll_chk && poll_bit) begin
            if (state == POLL_RDY) begin
              key_loaded     <= 1'b1;
              loaded_key     <= key_q;
              loaded_keylen  <= keylen_q;
              state          <= WR_BLK;
              idx            <= 4'd1;
              aes_cs         <= 1'b1;
              aes_we         <= 1'b1;
              aes_address    <= 8'h20;
              aes_write_data <= block_q[31:0];
            end else begin
              state       <= RD_RES;
              idx         <= 4'd0;
              aes_cs      <= 1'b1;
              aes_address <= 8'h30;
            end
          end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
            // the key core state is unknown after an init that never completed
            if (state == POLL_RDY) key_loaded <= 1'b0;
            state     <= RESP;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= '0;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            poll_chk <= ~poll_chk;
            if (poll_chk) begin
              aes_cs      <= 1'b1;
              aes_address <= ADDR_STATUS;
            end
          end
        end
        WR_BLK: begin
          aes_cs <= 1'b1;
          aes_we <= 1'b1;
          if (idx == 4'd4) begin
            state          <= WR_NEXT;
            aes_address    <= ADDR_CTRL;
            aes_write_data <= 32'h2;
          end else begin
            aes_address    <= {4'h2, idx};
            aes_write_data <= block_q[{idx[1:0], 5'b0} +: 32];
            idx            <= idx + 4'd1;
          end
        end
        WR_NEXT: begin
          state      <= SETTLE;
          settle_vld <= 1'b1;
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
        end
        RD_RES: begin
          // read data trails its strobe by one cycle, so word idx-1 lands now
          if (idx != 4'd0) res_data[{idx_m1[1:0], 5'b0} +: 32] <= aes_read_data;
          if (idx < 4'd3) begin
            aes_cs      <= 1'b1;
            aes_address <= {4'h3, idx + 4'd1};
          end
          if (idx == 4'd4) begin
            state     <= RESP;
            res_valid <= 1'b1;
            res_err   <= 1'b0;
          end
          idx <= idx + 4'd1;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer: a small aes wrapper bus model plus
// hand-computed bus traces and results for each job.
module tb_aes_job_sequencer;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [255:0] job_key = '0;
  logic [127:0] job_block = '0;
  logic         job_encdec = 1'b0;
  logic         job_keylen = 1'b0;
  logic         job_key_reuse = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic         res_err;
  logic         busy;
  logic         aes_cs;
  logic         aes_we;
  logic [7:0]   aes_address;
  logic [31:0]  aes_write_data;
  logic [31:0]  aes_read_data = '0;

  always #5 clk = ~clk;

  aes_job_sequencer #(.POLL_TIMEOUT(16), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_block(job_block),
    .job_encdec(job_encdec), .job_keylen(job_keylen), .job_key_reuse(job_key_reuse),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
    .aes_write_data(aes_write_data), .aes_read_data(aes_read_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wrapper model: status ready/valid rise 5 cycles after init/next, result words fixed
  logic [127:0] result_mem = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [40:0]  trace[$];
  logic [40:0]  exp_q[$];
  int           n_stat_rd = 0;
  int           idle_viol = 0;
  logic [7:0]   pend_addr = '0;
  logic         pend_rd = 1'b0;
  logic         st_rdy = 1'b0, st_vld = 1'b0;
  int           rdy_t = 0, vld_t = 0;
  bit           never_valid = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend_rd = 1'b0;
      aes_read_data = '0;
    end else begin
      if (rdy_t > 0) begin rdy_t--; if (rdy_t == 0) st_rdy = 1'b1; end
      if (vld_t > 0) begin vld_t--; if (vld_t == 0) st_vld = 1'b1; end
      if (pend_rd) begin
        if (pend_addr == 8'h09) aes_read_data = {30'b0, st_vld, st_rdy};
        else if (pend_addr[7:2] == 6'b001100) aes_read_data = result_mem[{pend_addr[1:0], 5'b0} +: 32];
        else aes_read_data = '0;
      end else begin
        aes_read_data = '0;
      end
      pend_rd   = aes_cs && !aes_we;
      pend_addr = aes_address;
      if (aes_cs) begin
        if (aes_address == 8'h09 && !aes_we) n_stat_rd++;
        else trace.push_back({aes_we, aes_address, aes_we ? aes_write_data : 32'h0});
        if (aes_we && aes_address == 8'h08) begin
          if (aes_write_data[0]) begin st_rdy = 1'b0; rdy_t = 5; end
          if (aes_write_data[1]) begin st_vld = 1'b0; vld_t = never_valid ? 0 : 5; end
        end
      end else if (aes_address != 8'h00 || aes_write_data != 32'h0) begin
        idle_viol++;
      end
    end
  end

  task automatic build_exp(input logic [255:0] k, input logic [127:0] b, input logic enc,
                           input logic kl, input bit full, input bit timeout);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h0a, {30'b0, kl, enc}});
    if (full) begin
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'h10 + 8'(i), k[32*i +: 32]});
      exp_q.push_back({1'b1, 8'h08, 32'h1});
    end
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h20 + 8'(i), b[32*i +: 32]});
    exp_q.push_back({1'b1, 8'h08, 32'h2});
    if (!timeout)
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h30 + 8'(i), 32'h0});
  endtask

  task automatic submit(input logic [255:0] k, input logic [127:0] b, input logic enc,
                        input logic kl, input logic reuse, input string tag);
    int n;
    @(posedge clk);
    trace.delete();
    n_stat_rd = 0;
    @(negedge clk);
    job_key = k; job_block = b; job_encdec = enc; job_keylen = kl; job_key_reuse = reuse;
    job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, n < 100, 1'b1);
    @(negedge clk);
    job_valid = 1'b0;
    chk({tag, "_busy"}, {job_ready, busy}, 2'b01);
  endtask

  task automatic run_job(input string tag, input logic [255:0] k, input logic [127:0] b,
                         input logic enc, input logic kl, input logic reuse, input bit full,
                         input bit timeout, input int exp_rd, input int hold);
    int n;
    bit stable;
    logic [127:0] d0;
    logic [40:0] t, e;
    int diffs;
    build_exp(k, b, enc, kl, full, timeout);
    submit(k, b, enc, kl, reuse, tag);
    n = 0;
    while (!res_valid && n < 600) begin @(negedge clk); n++; end
    chk({tag, "_res_seen"}, n < 600, 1'b1);
    chk({tag, "_res_err"}, res_err, timeout);
    chk({tag, "_res_data"}, res_data, timeout ? 128'h0 : 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk({tag, "_job_ready_resp"}, job_ready, 1'b0);
    d0 = res_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== d0 || job_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, stable, 1'b1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_after_hs"}, {res_valid, job_ready, busy}, 3'b010);
    chk({tag, "_trace_len"}, trace.size(), exp_q.size());
    diffs = 0;
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++) begin
      t = trace[i];
      e = exp_q[i];
      if (t !== e) diffs++;
    end
    chk({tag, "_trace_diffs"}, diffs, 0);
    if (exp_rd >= 0) chk({tag, "_stat_reads"}, n_stat_rd, exp_rd);
    else chk({tag, "_stat_polled"}, n_stat_rd > 0, 1'b1);
  endtask

  logic [255:0] k1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  logic [255:0] k2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [127:0] b1 = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] b2 = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_res", {res_valid, res_err, busy}, 3'b000);
    chk("rst_res_data", res_data, 128'h0);
    chk("rst_bus", {aes_cs, aes_we, aes_address, aes_write_data}, 42'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run_job("j1_full",     k1, b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 20);
    run_job("j2_reuse",    k1, b2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0);
    run_job("j3_newkey",   k2, b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
    run_job("j4_keylen",   k2, b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0);
    run_job("j5_reuse256", k2, b2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    never_valid = 1'b1;
    run_job("j6_timeout",  k2, b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8, 3);
    never_valid = 1'b0;

    // abandon a job part-way through the key load
    submit(k2, b1, 1'b1, 1'b1, 1'b0, "j7_rst");
    n = 0;
    while (trace.size() < 4 && n < 50) begin @(negedge clk); n++; end
    chk("j7_in_wr_key", aes_cs && aes_we && aes_address[7:4] == 4'h1, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("j7_rst_bus", {aes_cs, aes_we, aes_address, aes_write_data}, 42'h0);
    chk("j7_rst_ctl", {job_ready, busy, res_valid, res_err}, 4'b1000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_job("j8_after_rst", k2, b2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0);

    chk("bus_idle_zero", idle_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
